// File: rtl/approx_mult_pkg.sv
// Shared definitions for the approximate multiplier pipeline: product width,
// mode encoding and the truncation bias-compensation constant.
package approx_mult_pkg;

  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_APPROX = 1'b1;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  // Half-weight of the lowest kept column: recentres the truncation error.
  function automatic logic [31:0] comp_const(input int trunc_col);
    return 32'd1 << (trunc_col - 1);
  endfunction

endpackage

// File: rtl/approx_trunc_rows.sv
// Combinational partial-product sum of the low (approximated) multiplier rows,
// keeping only bits at or above column TRUNC_COL.
module approx_trunc_rows
  import approx_mult_pkg::*;
#(
  parameter int W           = 8,
  parameter int APPROX_ROWS = 4,
  parameter int TRUNC_COL   = 8
) (
  input  logic [APPROX_ROWS-1:0] x_lo,
  input  logic [W-1:0]           y,
  output logic [prod_w(W)-1:0]   c
);

  localparam int PW = prod_w(W);

  always_comb begin
    c = '0;
    for (int i = 0; i < APPROX_ROWS; i++) begin
      // Row i sits at column i; bits below TRUNC_COL are dropped entirely.
      if (x_lo[i] && ((TRUNC_COL - i) < W))
        c = c + (PW'(y >> (TRUNC_COL - i)) << TRUNC_COL);
    end
  end

endmodule

// File: rtl/approx_mult_pipe.sv
// Two-stage unsigned exact/approximate multiplier with valid/ready handshake.
// Optional build macro APPROX_MULT_BIAS_COMP_EN adds truncation bias compensation.
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int W           = 8,
  parameter int APPROX_ROWS = 4,
  parameter int TRUNC_COL   = 8,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         x,
  input  logic [W-1:0]         y,
  input  logic                 approx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [prod_w(W)-1:0] z,
  output logic                 z_approx,
  output logic [CNT_W-1:0]     approx_cnt
);

  localparam int PW = prod_w(W);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic          vld_p1, vld_p2;
  logic [PW-1:0] h_p1, part_p1;
  logic          approx_p1;
  logic [PW-1:0] z_p2;
  logic          z_approx_p2;
  logic [CNT_W-1:0] cnt_q;

  logic          s2_load, accept;
  logic [PW-1:0] h_p0, lo_exact_p0, c_p0, sum_p1;

  assign s2_load  = !vld_p2 || out_ready;
  assign in_ready = !vld_p1 || s2_load;
  assign accept   = in_valid && in_ready;

  // ---- Stage 0 -> 1: row split, high rows always exact ----
  assign h_p0        = (PW'(y) * PW'(x[W-1:APPROX_ROWS])) << APPROX_ROWS;
  assign lo_exact_p0 = PW'(y) * PW'(x[APPROX_ROWS-1:0]);

  approx_trunc_rows #(
    .W          (W),
    .APPROX_ROWS(APPROX_ROWS),
    .TRUNC_COL  (TRUNC_COL)
  ) u_trunc (
    .x_lo(x[APPROX_ROWS-1:0]),
    .y   (y),
    .c   (c_p0)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      h_p1      <= h_p0;
      part_p1   <= (approx == MODE_APPROX) ? c_p0 : lo_exact_p0;
      approx_p1 <= approx;
    end
  end

  // ---- Stage 1 -> 2: final sum ----
`ifdef APPROX_MULT_BIAS_COMP_EN
  localparam logic [PW-1:0] COMP = PW'(comp_const(TRUNC_COL));
  always_comb begin
    sum_p1 = h_p1 + part_p1;
    if (approx_p1 == MODE_APPROX)
      sum_p1 = sum_p1 + COMP;
  end
`else
  always_comb begin
    sum_p1 = h_p1 + part_p1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      z_p2        <= '0;
      z_approx_p2 <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (in_ready)
        vld_p1 <= accept;
      if (s2_load)
        vld_p2 <= vld_p1;
      if (s2_load && vld_p1) begin
        z_p2        <= sum_p1;
        z_approx_p2 <= approx_p1;
      end
      if (accept && (approx == MODE_APPROX))
        cnt_q <= sat_inc(cnt_q);
    end
  end

  assign out_valid  = vld_p2;
  assign z          = z_p2;
  assign z_approx   = z_approx_p2;
  assign approx_cnt = cnt_q;

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Directed self-checking bench for approx_mult_pipe at default parameters.
module tb_approx_mult_pipe;

  localparam int W = 8;
  localparam int AR = 4;
  localparam int TC = 8;
  localparam int CNT_W = 16;
`ifdef APPROX_MULT_BIAS_COMP_EN
  localparam int COMP = 128;
`else
  localparam int COMP = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [W-1:0]      x = '0;
  logic [W-1:0]      y = '0;
  logic              approx = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [2*W-1:0]    z;
  logic              z_approx;
  logic [CNT_W-1:0]  approx_cnt;

  int n_cmp = 0;
  int n_err = 0;

  approx_mult_pipe #(.W(W), .APPROX_ROWS(AR), .TRUNC_COL(TC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .approx(approx), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .z_approx(z_approx), .approx_cnt(approx_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference straight from the arithmetic definition (W=8, 4 rows, column 8).
  function automatic int model(input logic [7:0] xx, input logic [7:0] yy, input logic a);
    int r;
    if (!a) return int'(xx) * int'(yy);
    r = int'(yy) * int'(xx >> 4) * 16;
    for (int i = 0; i < 4; i++)
      if (xx[i]) r = r + (int'(yy >> (8 - i)) * 256);
    return (r + COMP) % 65536;
  endfunction

  // Single transaction into an empty pipe; result checked 2 cycles after accept.
  task automatic single(input string tag, input logic [7:0] xx, input logic [7:0] yy,
                        input logic a, input int exp_z);
    @(negedge clk);
    check_val({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1; x = xx; y = yy; approx = a;
    @(negedge clk);
    in_valid = 1'b0;
    check_val({tag, "_lat1_valid"}, out_valid, 0);
    @(negedge clk);
    check_val({tag, "_valid"}, out_valid, 1);
    check_val({tag, "_z"}, z, exp_z);
    check_val({tag, "_tag"}, z_approx, a);
  endtask

  logic [7:0] sx [8];
  logic [7:0] sy [8];
  logic       sa [8];
  logic [7:0] bx [3] = '{8'h12, 8'h34, 8'h56};
  logic [7:0] by [3] = '{8'h9A, 8'hBC, 8'hDE};
  int n_app;
  int idx;
  logic fire;
  logic [15:0] z_hold;

  initial begin
    #12;
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_z", z, 0);
    check_val("rst_z_approx", z_approx, 0);
    check_val("rst_cnt", approx_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    single("ff_exact", 8'hFF, 8'hFF, 1'b0, 65025);
    single("ff_approx", 8'hFF, 8'hFF, 1'b1, 64016 + COMP);
    check_val("cnt_after_ff", approx_cnt, 1);
    single("0f_exact", 8'h0F, 8'h0F, 1'b0, 225);
    single("0f_approx", 8'h0F, 8'h0F, 1'b1, 0 + COMP);
    single("10_approx", 8'h10, 8'h10, 1'b1, 256 + COMP);
    check_val("cnt_after_dir", approx_cnt, 3);

    // Back-to-back stream, out_ready held high.
    n_app = 0;
    for (int i = 0; i < 8; i++) begin
      sx[i] = 8'($urandom_range(0, 255));
      sy[i] = 8'($urandom_range(0, 255));
      sa[i] = 1'($urandom_range(0, 1));
      if (sa[i]) n_app++;
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        check_val($sformatf("stream%0d_valid", k - 2), out_valid, 1);
        check_val($sformatf("stream%0d_z", k - 2), z, model(sx[k-2], sy[k-2], sa[k-2]));
      end
      if (k < 8) begin
        in_valid = 1'b1; x = sx[k]; y = sy[k]; approx = sa[k];
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    check_val("stream_drain", out_valid, 0);
    check_val("cnt_after_stream", approx_cnt, 3 + n_app);

    // Backpressure: out_ready low for 5 cycles with in_valid high.
    out_ready = 1'b0;
    idx = 0;
    in_valid = 1'b1; x = bx[0]; y = by[0]; approx = 1'b0;
    z_hold = '0;
    for (int c = 0; c < 5; c++) begin
      fire = in_ready;
      @(posedge clk);
      #1;
      if (fire && idx < 2) begin
        idx++;
        x = bx[idx]; y = by[idx];
      end else if (fire) begin
        idx++;
      end
      @(negedge clk);
      if (c == 1) z_hold = z;
    end
    in_valid = 1'b0;
    check_val("bp_accepted", idx, 2);
    check_val("bp_in_ready", in_ready, 0);
    check_val("bp_out_valid", out_valid, 1);
    check_val("bp_z_stable", z, z_hold);
    check_val("bp_z_first", z, model(bx[0], by[0], 1'b0));
    out_ready = 1'b1;
    @(negedge clk);
    check_val("bp_rel_valid1", out_valid, 1);
    check_val("bp_rel_z1", z, model(bx[1], by[1], 1'b0));
    @(negedge clk);
    check_val("bp_rel_empty", out_valid, 0);

    // Reset in the middle of a stream.
    in_valid = 1'b1; x = 8'hA5; y = 8'h3C; approx = 1'b1;
    @(negedge clk);
    x = 8'h5A; y = 8'hC3;
    @(negedge clk);
    check_val("mid_valid_pre", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_valid", out_valid, 0);
    check_val("mid_rst_z", z, 0);
    check_val("mid_rst_cnt", approx_cnt, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_empty", out_valid, 0);
    single("post_rst", 8'h07, 8'h09, 1'b0, 63);
    check_val("post_rst_cnt", approx_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
